memoria_dados_pipeline: RTL and testbench
=========================================

# memoria_dados_pipeline

Parametrised data memory for the processor datapath with byte/halfword/word access, sign or zero extension on loads, a configurable read-latency pipeline and an error response for illegal requests. Sits in the MEM stage, where the single-cycle word-only memory was. Writes are synchronous on the rising edge; read data returns a fixed LATENCIA cycles after the request, qualified by `valido`.

## Interface
- PROFUNDIDADE, 512: number of 32-bit words; valid byte addresses are 0 .. 4*PROFUNDIDADE-1.
- LATENCIA, 1: read latency in cycles, legal range 1..4.
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears the pipeline and outputs, not the array.
- lerMemoria  input  1  load request.
- escreverNaMemoria  input  1  store request.
- endereco  input  32  byte address.
- dadosEscrita  input  32  store data; byte/half taken from bits [7:0]/[15:0].
- tamanho  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- semSinal  input  1  1 = zero-extend the load, 0 = sign-extend; ignored for word and store.
- lerDados  output  32  load response data.
- valido  output  1  one-cycle pulse marking a response.
- erro  output  1  qualifies a response as an error; only high together with `valido`.

## Operation
- A request is accepted on every rising edge where `lerMemoria | escreverNaMemoria` and `reset` is low. There is no stall: one request per cycle.
- Word index is `endereco[31:2]`; lane offset is `endereco[1:0]`.
- Illegal requests are recorded at accept, perform no array access, and produce `valido=1, erro=1, lerDados=0`, LATENCIA cycles later:
  - both strobes high;
  - `tamanho`=11;
  - word index ≥ PROFUNDIDADE;
  - misaligned access (see Configuration).
- Store: at the accept edge, only the addressed lanes are written:
  - byte: lane `endereco[1:0]`;
  - half: lanes {1,0} or {3,2} by `endereco[1]`;
  - word: all four lanes.
  - Other lanes are untouched. A legal store produces no response.
- Load: the word is sampled at the accept edge. The array is read before any store at that same edge, which is impossible anyway since the two strobes are mutually exclusive. The lane is selected and shifted to bit 0, then extended per `semSinal`. The result travels down a LATENCIA-deep shift pipeline of {valid, erro, dados}.
- A store accepted at edge N is visible to a load accepted at edge N+1.
- The array is not reset. Contents are undefined until written.

## Timing
- Reset values: `lerDados`=0, `valido`=0, `erro`=0, all pipeline stages invalid.
- Load or error response:
  - accepted at edge N;
  - `valido` and `lerDados` are registered outputs at edge N+LATENCIA;
  - they hold for one cycle;
  - `lerDados` returns to 0 when `valido` is low.
- Back-to-back requests yield back-to-back responses in request order.
- Reset asserted mid-flight: all in-flight responses are dropped immediately, with no pulse after reset releases. Stores already accepted remain in the array.
- Requests presented while `reset` is high are ignored.

## Configuration
- `MEMORIA_ALINHAMENTO_EN` defined:
  - halfword with `endereco[0]`=1, or word with `endereco[1:0]`≠00, is illegal;
  - it yields an error response and no write.
- Undefined:
  - no alignment check;
  - halfword ignores `endereco[0]`;
  - word ignores `endereco[1:0]`;
  - the access proceeds on the aligned lanes.
- Range and reserved-`tamanho` checks exist in both builds.

## Test plan
- **Word store/load.** Store word 0x8765_4321 at address 0x10. Load word at 0x10 with LATENCIA=1.
  - Required: `valido` exactly one cycle after the load edge, `lerDados`=0x8765_4321, `erro`=0.
- **Byte/half lanes.** Over word 0x8765_4321:
  - store byte 0xAA at 0x11 → load word reads 0x8765_AA21;
  - load byte 0x11 with `semSinal`=0 → 0xFFFF_FFAA;
  - same load with `semSinal`=1 → 0x0000_00AA;
  - load half 0x12 with `semSinal`=0 → 0xFFFF_8765.
- **Latency and pipelining.** LATENCIA=3. Issue loads to words 0,1,2 on consecutive edges (contents 1,2,3).
  - Required: `valido` high for three consecutive cycles starting 3 cycles after the first load, data 1,2,3 in order.
- **Errors.**
  - Load at 4*PROFUNDIDADE → `valido=1, erro=1, lerDados=0`.
  - Both strobes high → error response and no array change.
  - `tamanho`=11 → error response.
  - With `MEMORIA_ALINHAMENTO_EN`, store word at 0x12 → error and word 4 unchanged.
  - Without the macro, the same store writes word 4.
- **Reset mid-flight.** LATENCIA=4. Issue a load, assert `reset` 2 cycles later for 1 cycle.
  - Required: outputs go to 0 immediately and no `valido` pulse ever appears.
  - A subsequent load of a previously stored word still returns its value.

Source files
------------

// File: rtl/memoria_dados_pipeline_if.sv
// Request/response bundle of the MEM-stage data memory.
// The master side issues loads/stores; the slave side returns load/error responses.
interface memoria_dados_pipeline_if;
  logic        lerMemoria;
  logic        escreverNaMemoria;
  logic [31:0] endereco;
  logic [31:0] dadosEscrita;
  logic [1:0]  tamanho;
  logic        semSinal;
  logic [31:0] lerDados;
  logic        valido;
  logic        erro;

  modport master (
    output lerMemoria, escreverNaMemoria, endereco, dadosEscrita, tamanho, semSinal,
    input  lerDados, valido, erro
  );

  modport slave (
    input  lerMemoria, escreverNaMemoria, endereco, dadosEscrita, tamanho, semSinal,
    output lerDados, valido, erro
  );
endinterface

// File: rtl/memoria_dados_pipeline.sv
// Byte/half/word data memory with sign/zero-extended loads, a LATENCIA-cycle read pipeline and
// error responses. Optional alignment checking is enabled by defining MEMORIA_ALINHAMENTO_EN.
module memoria_dados_pipeline #(
  parameter int PROFUNDIDADE = 512,
  parameter int LATENCIA     = 1
) (
  input logic                     clock,
  input logic                     reset,
  memoria_dados_pipeline_if.slave bus
);
  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  typedef enum logic [1:0] {
    TAM_BYTE = 2'b00,
    TAM_HALF = 2'b01,
    TAM_WORD = 2'b10,
    TAM_RSVD = 2'b11
  } tamanho_e;

  tamanho_e    tam;
  logic [29:0] word_idx;
  logic [1:0]  off;
  logic [AW-1:0] idx_w;
  logic        accept, misaligned, illegal, do_read, do_write;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  assign tam      = tamanho_e'(bus.tamanho);
  assign word_idx = bus.endereco[31:2];
  assign off      = bus.endereco[1:0];
  assign idx_w    = word_idx[AW-1:0];

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    accept     = (bus.lerMemoria | bus.escreverNaMemoria) & ~reset;
    misaligned = 1'b0;
`ifdef MEMORIA_ALINHAMENTO_EN
    misaligned = ((tam == TAM_HALF) && off[0]) || ((tam == TAM_WORD) && (off != 2'b00));
`endif
    illegal  = accept & ((bus.lerMemoria & bus.escreverNaMemoria) | (tam == TAM_RSVD) |
                         ({2'b00, word_idx} >= 32'(PROFUNDIDADE)) | misaligned);
    do_read  = accept & bus.lerMemoria & ~illegal;
    do_write = accept & bus.escreverNaMemoria & ~illegal;
    wr_be    = 4'b0000;
    wr_data  = bus.dadosEscrita;
    case (tam)
      TAM_BYTE: begin
        wr_be   = 4'b0001 << off;
        wr_data = {4{bus.dadosEscrita[7:0]}};
      end
      TAM_HALF: begin
        wr_be   = off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.dadosEscrita[15:0]}};
      end
      TAM_WORD: wr_be = 4'b1111;
      default:  wr_be = 4'b0000;
    endcase
  end

  // Array plus synchronous read register: the read samples the old word at the accept edge.
  logic [31:0] mem_q [PROFUNDIDADE];
  logic [31:0] rd_word_d, rd_word_q;

  assign rd_word_d = do_read ? mem_q[idx_w] : rd_word_q;

  // NOTE: the array and its read register have no reset; contents stay undefined until written,
  // and the read register is only consumed when its qualifying valid bit is set.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[idx_w][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    rd_word_q <= rd_word_d;
  end

  // Request capture stage: metadata needed to format the word one cycle later.
  logic       req_vld_d, req_vld_q;
  logic       req_err_d, req_err_q;
  logic       req_sgn_d, req_sgn_q;
  tamanho_e   req_tam_d, req_tam_q;
  logic [1:0] req_off_d, req_off_q;

  always_comb begin
    req_vld_d = do_read | illegal;
    req_err_d = illegal;
    req_sgn_d = bus.semSinal;
    req_tam_d = tam;
    req_off_d = off;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_vld_q <= 1'b0;
      req_err_q <= 1'b0;
      req_sgn_q <= 1'b0;
      req_tam_q <= TAM_BYTE;
      req_off_q <= 2'b00;
    end else begin
      req_vld_q <= req_vld_d;
      req_err_q <= req_err_d;
      req_sgn_q <= req_sgn_d;
      req_tam_q <= req_tam_d;
      req_off_q <= req_off_d;
    end
  end

  // Lane select and extension, then the LATENCIA-deep response pipeline.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        pipe_vld_d [LATENCIA];
  logic        pipe_vld_q [LATENCIA];
  logic        pipe_err_d [LATENCIA];
  logic        pipe_err_q [LATENCIA];
  logic [31:0] pipe_dat_d [LATENCIA];
  logic [31:0] pipe_dat_q [LATENCIA];

  always_comb begin
    case (req_off_q)
      2'd0:    byte_sel = rd_word_q[7:0];
      2'd1:    byte_sel = rd_word_q[15:8];
      2'd2:    byte_sel = rd_word_q[23:16];
      default: byte_sel = rd_word_q[31:24];
    endcase
    half_sel = req_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (req_tam_q)
      TAM_BYTE: load_ext = req_sgn_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      TAM_HALF: load_ext = req_sgn_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      TAM_WORD: load_ext = rd_word_q;
      default:  load_ext = 32'd0;
    endcase
    pipe_vld_d[0] = req_vld_q;
    pipe_err_d[0] = req_vld_q & req_err_q;
    pipe_dat_d[0] = (req_vld_q && !req_err_q) ? load_ext : 32'd0;
    for (int i = 1; i < LATENCIA; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCIA; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_err_q[i] <= 1'b0;
        pipe_dat_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < LATENCIA; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_err_q[i] <= pipe_err_d[i];
        pipe_dat_q[i] <= pipe_dat_d[i];
      end
    end
  end

  assign bus.valido   = pipe_vld_q[LATENCIA-1];
  assign bus.erro     = pipe_err_q[LATENCIA-1];
  assign bus.lerDados = pipe_dat_q[LATENCIA-1];
endmodule

// File: tb/tb_memoria_dados_pipeline.sv
// Scoreboard bench: the same request stream drives three memories (LATENCIA 1, 3, 4); a
// reference model predicts each response and when it must appear.
module tb_memoria_dados_pipeline;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memoria_dados_pipeline_if b1 ();
  memoria_dados_pipeline_if b3 ();
  memoria_dados_pipeline_if b4 ();

  memoria_dados_pipeline #(.PROFUNDIDADE(512), .LATENCIA(1)) u_l1 (.clock(clock), .reset(reset), .bus(b1));
  memoria_dados_pipeline #(.PROFUNDIDADE(512), .LATENCIA(3)) u_l3 (.clock(clock), .reset(reset), .bus(b3));
  memoria_dados_pipeline #(.PROFUNDIDADE(512), .LATENCIA(4)) u_l4 (.clock(clock), .reset(reset), .bus(b4));

  typedef struct {
    int          due;
    logic        erro;
    logic [31:0] dados;
  } exp_t;

  exp_t        sb [3][$];
  int          lat_of [3] = '{1, 3, 4};
  logic [31:0] model [512];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_bus(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdat, input logic [1:0] tam, input logic sgn);
    b1.lerMemoria = rd; b1.escreverNaMemoria = wr; b1.endereco = addr;
    b1.dadosEscrita = wdat; b1.tamanho = tam; b1.semSinal = sgn;
    b3.lerMemoria = rd; b3.escreverNaMemoria = wr; b3.endereco = addr;
    b3.dadosEscrita = wdat; b3.tamanho = tam; b3.semSinal = sgn;
    b4.lerMemoria = rd; b4.escreverNaMemoria = wr; b4.endereco = addr;
    b4.dadosEscrita = wdat; b4.tamanho = tam; b4.semSinal = sgn;
  endtask

  function automatic bit is_illegal(input logic rd, input logic wr, input logic [31:0] addr,
                                    input logic [1:0] tam);
    bit bad;
    bad = (rd && wr) || (tam == 2'b11) || (addr >= 32'd2048);
`ifdef MEMORIA_ALINHAMENTO_EN
    if (tam == 2'b01 && addr[0]) bad = 1'b1;
    if (tam == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] addr, input logic [1:0] tam,
                                           input logic sgn);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          o;
    w = model[addr[10:2]];
    o = int'(addr[1:0]);
    b = w[8*o +: 8];
    h = addr[1] ? w[31:16] : w[15:0];
    if (tam == 2'b00) return sgn ? {24'd0, b} : {{24{b[7]}}, b};
    if (tam == 2'b01) return sgn ? {16'd0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wdat, input logic [1:0] tam);
    int o;
    int k;
    k = int'(addr[10:2]);
    o = int'(addr[1:0]);
    if (tam == 2'b00) model[k][8*o +: 8] = wdat[7:0];
    else if (tam == 2'b01) begin
      if (addr[1]) model[k][31:16] = wdat[15:0];
      else         model[k][15:0]  = wdat[15:0];
    end else model[k] = wdat;
  endtask

  // Present one request for one edge; push expected responses with their due cycle.
  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdat, input logic [1:0] tam, input logic sgn);
    bit bad;
    logic [31:0] val;
    drive_bus(rd, wr, addr, wdat, tam, sgn);
    if (!reset) begin
      bad = is_illegal(rd, wr, addr, tam);
      val = 32'd0;
      if (rd && !bad) val = load_val(addr, tam, sgn);
      if (wr && !bad) model_write(addr, wdat, tam);
      if (rd || bad) begin
        for (int i = 0; i < 3; i++) sb[i].push_back('{cyc + 1 + lat_of[i], bad, val});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] wdat, input logic [1:0] tam);
    req(1'b0, 1'b1, addr, wdat, tam, 1'b0);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [1:0] tam, input logic sgn);
    req(1'b1, 1'b0, addr, 32'd0, tam, sgn);
  endtask

  task automatic idle(input int n);
    drive_bus(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic mon(input int i, input logic v, input logic e, input logic [31:0] d);
    exp_t x;
    string p;
    p = $sformatf("L%0d_", lat_of[i]);
    if (reset) begin
      check({p, "reset_outputs"}, {30'd0, v, e, d}, 64'd0);
      sb[i].delete();
      return;
    end
    while (sb[i].size() > 0 && sb[i][0].due < cyc) begin
      check({p, "missing_response"}, 64'd0, 64'd1);
      void'(sb[i].pop_front());
    end
    if (v) begin
      if (sb[i].size() == 0) check({p, "spurious_valido"}, 64'(v), 64'd0);
      else begin
        x = sb[i].pop_front();
        check({p, "response_cycle"}, 64'(cyc), 64'(x.due));
        check({p, "erro"}, 64'(e), 64'(x.erro));
        check({p, "lerDados"}, 64'(d), 64'(x.dados));
      end
    end else begin
      check({p, "idle_outputs"}, {31'd0, e, d}, 64'd0);
    end
  endtask

  always @(negedge clock) begin
    mon(0, b1.valido, b1.erro, b1.lerDados);
    mon(1, b3.valido, b3.erro, b3.lerDados);
    mon(2, b4.valido, b4.erro, b4.lerDados);
  end

  initial begin
    drive_bus(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Word store/load, then byte/half lane accesses over the same word.
    st(32'h10, 32'h8765_4321, 2'b10);
    ld(32'h10, 2'b10, 1'b0);
    st(32'h11, 32'h0000_00AA, 2'b00);
    ld(32'h10, 2'b10, 1'b0);
    ld(32'h11, 2'b00, 1'b0);
    ld(32'h11, 2'b00, 1'b1);
    ld(32'h12, 2'b01, 1'b0);
    ld(32'h12, 2'b01, 1'b1);
    ld(32'h13, 2'b00, 1'b0);
    ld(32'h10, 2'b00, 1'b0);

    // Back-to-back loads after back-to-back stores.
    st(32'h0, 32'd1, 2'b10);
    st(32'h4, 32'd2, 2'b10);
    st(32'h8, 32'd3, 2'b10);
    ld(32'h0, 2'b10, 1'b0);
    ld(32'h4, 2'b10, 1'b0);
    ld(32'h8, 2'b10, 1'b0);
    idle(2);

    // Upper halfword store into a cleared word; last legal word of the array.
    st(32'h14, 32'd0, 2'b10);
    st(32'h16, 32'h1234_BEEF, 2'b01);
    ld(32'h14, 2'b10, 1'b0);
    st(32'h7FC, 32'hCAFE_F00D, 2'b10);
    ld(32'h7FC, 2'b10, 1'b0);
    ld(32'h7FF, 2'b00, 1'b1);

    // Error responses and the absence of side effects.
    ld(32'h800, 2'b10, 1'b0);
    st(32'h800, 32'h5555_5555, 2'b10);
    req(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0);
    ld(32'h10, 2'b10, 1'b0);
    ld(32'h10, 2'b11, 1'b0);
    st(32'h10, 32'h0BAD_0BAD, 2'b11);
    ld(32'h10, 2'b10, 1'b0);
    st(32'h12, 32'h1122_3344, 2'b10);
    ld(32'h10, 2'b10, 1'b0);
    st(32'h17, 32'h0000_7777, 2'b01);
    ld(32'h14, 2'b10, 1'b0);
    idle(6);

    // Reset mid-flight: in-flight loads dropped, request during reset ignored, array kept.
    ld(32'h4, 2'b10, 1'b0);
    idle(1);
    reset = 1'b1;
    drive_bus(1'b1, 1'b0, 32'h8, 32'd0, 2'b10, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(6);
    ld(32'h8, 2'b10, 1'b0);
    ld(32'h10, 2'b10, 1'b0);
    idle(6);

    // Mixed random traffic over a fully written window, with occasional illegal requests.
    for (int k = 0; k < 8; k++) st(32'(4 * k), $urandom, 2'b10);
    for (int n = 0; n < 60; n++) begin
      logic        rd, wr;
      logic [31:0] a;
      int          r;
      r  = $urandom_range(0, 19);
      rd = (r < 10) || (r == 19);
      wr = (r >= 10);
      a  = (r == 18) ? 32'h800 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 31));
      req(rd, wr, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle(8);

    @(negedge clock);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("L%0d_drain", lat_of[i]), 64'(sb[i].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
